botao_cond: RTL and testbench

Pedestrian push-button conditioner sitting directly upstream of the traffic-light controller, which consumes its `bt` request. It synchronises and debounces the raw button input, then converts one valid press into a fixed-length `bt` pulse. The pulse spans one full controller cycle. After the pulse the block locks out further presses and requires the button to be released before it re-arms.

---
 rtl/semaforo_pkg.sv | 22 ++
 rtl/sync2.sv | 21 ++
 rtl/botao_cond.sv | 104 ++++++++++
 tb/tb_botao_cond.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared encodings and default timing for the pedestrian button path of the traffic-light controller.
package semaforo_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    ACTIVE   = 3'd2,
    LOCKOUT  = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  // Light controller phase lengths; one full cycle sets the request hold time.
  localparam int unsigned VERDE_CYCLES    = 2;
  localparam int unsigned AMARELO_CYCLES  = 4;
  localparam int unsigned VERMELHO_CYCLES = 3;

  localparam int unsigned DEB_DEFAULT  = 4;
  localparam int unsigned HOLD_DEFAULT = VERDE_CYCLES + AMARELO_CYCLES + VERMELHO_CYCLES;
  localparam int unsigned LOCK_DEFAULT = 6;
  localparam int unsigned CNT_W_DEFAULT = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with synchronous reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/botao_cond.sv
// Push-button conditioner: debounce, fixed-length bt pulse, lockout until release.
// Define BOTAO_SYNC_EN to place a 2-flop synchroniser on bt_raw.
module botao_cond
  import semaforo_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_DEFAULT,
  parameter int unsigned LOCK_CYCLES = LOCK_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic bt_raw,
  output logic bt,
  output logic lock
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic             s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             bt_nx, lock_nx;

`ifdef BOTAO_SYNC_EN
  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bt_raw),
    .q   (s)
  );
`else
  assign s = bt_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bt    <= 1'b0;
      lock  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bt    <= bt_nx;
      lock  <= lock_nx;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_nx = DEBOUNCE;
          cnt_nx   = '0;
        end
      end
      DEBOUNCE: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx = ACTIVE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt == HOLD_LAST) begin
          state_nx = LOCKOUT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      LOCKOUT: begin
        if (cnt == LOCK_LAST) begin
          state_nx = s ? RELEASE : IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!s) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    bt_nx   = (state_nx == ACTIVE);
    lock_nx = (state_nx == LOCKOUT) || (state_nx == RELEASE);
  end

endmodule

// File: tb/tb_botao_cond.sv
// Scenario bench for botao_cond; expected {bt,lock} per cycle derived from press timing.
module tb_botao_cond;

`ifdef BOTAO_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk;
  logic rst;
  logic bt_raw;
  logic bt;
  logic lock;

  typedef struct {
    int         k;
    logic [1:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  botao_cond dut (
    .clk    (clk),
    .rst    (rst),
    .bt_raw (bt_raw),
    .bt     (bt),
    .lock   (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one cycle and sample just after the following rising edge.
  task automatic drive(input logic raw, input logic r);
    bt_raw = raw;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      e.k = k;
      e.v = 2'b00;
      sb.push_back(e);
      drive((k < 3) ? 1'b1 : 1'b0, (k < 2) ? 1'b1 : 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({bt, lock} !== e.v) begin
        n_bad++;
        $display("FAIL reset k=%0d {bt,lock}=%b expected %b", e.k, {bt, lock}, e.v);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    for (int k = 0; k < 14; k++) begin
      e.k = k;
      e.v = 2'b00;
      sb.push_back(e);
      drive((k < 3) ? 1'b1 : 1'b0, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({bt, lock} !== e.v) begin
        n_bad++;
        $display("FAIL glitch k=%0d {bt,lock}=%b expected %b", e.k, {bt, lock}, e.v);
      end
    end
  endtask

  task automatic test_held_press();
    exp_t e;
    for (int k = 0; k <= 40 + L; k++) begin
      e.k = k;
      e.v = {(k >= L + 4 && k <= L + 12), (k >= L + 13 && k < 30 + L)};
      sb.push_back(e);
      drive((k < 30) ? 1'b1 : 1'b0, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({bt, lock} !== e.v) begin
        n_bad++;
        $display("FAIL held_press k=%0d {bt,lock}=%b expected %b", e.k, {bt, lock}, e.v);
      end
    end
  endtask

  // A second press lands inside the lockout window and must not retrigger.
  task automatic test_ignored_press();
    exp_t e;
    logic raw;
    for (int k = 0; k <= 40 + L; k++) begin
      raw = ((k < 15) || (k >= 16 && k < 26)) ? 1'b1 : 1'b0;
      e.k = k;
      e.v = {(k >= L + 4 && k <= L + 12), (k >= L + 13 && k < 26 + L)};
      sb.push_back(e);
      drive(raw, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({bt, lock} !== e.v) begin
        n_bad++;
        $display("FAIL ignored_press k=%0d {bt,lock}=%b expected %b", e.k, {bt, lock}, e.v);
      end
    end
  endtask

  // Reset during the 4th bt cycle; held button gets a fresh full-latency pulse.
  task automatic test_reset_mid_pulse();
    exp_t e;
    int   r_k;
    int   k0;
    logic b;
    logic lk;
    r_k = L + 8;
    k0  = L + 9;
    for (int k = 0; k <= k0 + 2 * L + 32; k++) begin
      b  = ((k >= L + 4 && k < r_k) || (k >= k0 + L + 4 && k <= k0 + L + 12)) ? 1'b1 : 1'b0;
      lk = (k >= k0 + L + 13 && k < k0 + 2 * L + 25) ? 1'b1 : 1'b0;
      e.k = k;
      e.v = {b, lk};
      sb.push_back(e);
      drive((k < k0 + L + 25) ? 1'b1 : 1'b0, (k == r_k) ? 1'b1 : 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({bt, lock} !== e.v) begin
        n_bad++;
        $display("FAIL reset_mid_pulse k=%0d {bt,lock}=%b expected %b", e.k, {bt, lock}, e.v);
      end
    end
  endtask

  initial begin
    bt_raw = 1'b0;
    rst    = 1'b1;
    test_reset();
    test_glitch();
    test_held_press();
    test_ignored_press();
    test_reset_mid_pulse();
    test_held_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
